// File: rtl/rr_sel_arbiter.sv
// Registered 4-way round-robin arbiter feeding a 2-to-4 decoder select.
// Guarantees fair rotation, bounded hold time and an idle cycle between owners.
module rr_sel_arbiter #(
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   input  logic       done,
   output logic [1:0] sel,
   output logic       gnt_valid,
   output logic       timeout
);

   localparam int unsigned   CW        = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;
   localparam logic [CW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CW'(MAX_HOLD - 1);
   localparam logic [CW-1:0] CNT_MAX   = '1;

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   state_t        state;
   logic [1:0]    ptr;
   logic [CW-1:0] hold_cnt;

   logic [1:0]    winner;
   logic [1:0]    idx;
   logic          any_req;
   logic          rel_done;
   logic          rel_wd;
   logic          rel_to;
   logic          release_now;

   // First requester at or after ptr, wrapping modulo 4.
   always_comb begin
      winner  = ptr;
      idx     = ptr;
      any_req = 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
         idx = ptr + 2'(i);
         if (!any_req && req[idx]) begin
            winner  = idx;
            any_req = 1'b1;
         end
      end
   end

   always_comb begin
      rel_done    = done;
      rel_wd      = !req[sel];
      rel_to      = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
      release_now = rel_done | rel_wd | rel_to;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         sel       <= '0;
         gnt_valid <= 1'b0;
         timeout   <= 1'b0;
         ptr       <= '0;
         hold_cnt  <= '0;
      end else begin
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  sel       <= winner;
                  gnt_valid <= 1'b1;
                  hold_cnt  <= '0;
                  state     <= GRANT;
               end
            end
            GRANT: begin
               if (release_now) begin
                  gnt_valid <= 1'b0;
                  ptr       <= sel + 2'd1;
                  timeout   <= rel_to & ~rel_done & ~rel_wd;
                  state     <= IDLE;
               end else if (hold_cnt != CNT_MAX) begin
                  // Saturates so an unlimited hold can never wrap.
                  hold_cnt <= hold_cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/rr_sel_arbiter.md
Name: rr_sel_arbiter

Overview:
- Registered 4-way round-robin arbiter that produces a 2-bit select code plus a valid flag for the downstream decoder_2to4 stage.
- The decoder converts `sel` into one-hot enables for four shared-resource clients.
- Guarantees fair rotation, a bounded hold time and a break-before-make gap, so the decoder's one-hot outputs never switch directly between two owners.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one grant may be held before forced release; 0 = unlimited.

Ports:
- clk  input  1  single system clock, rising-edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- req  input  4  request vector; req[i] high = client i wants the resource.
- done  input  1  current owner releases the resource; sampled only while gnt_valid=1.
- sel  output  2  index of current/last granted client; drives decoder sel.
- gnt_valid  output  1  sel denotes an active grant.
- timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - rst_n low asynchronously forces: state=IDLE, sel=2'b00, gnt_valid=0, timeout=0, ptr=2'b00, hold_cnt=0.
  - Reset deassertion is assumed synchronised externally.
- All outputs are registered; no combinational path from inputs to outputs.
- State IDLE (gnt_valid=0):
  - If req!=0, select the first set bit searching from ptr upward, modulo 4 (ptr, ptr+1, ptr+2, ptr+3).
  - At the next edge: sel<=winner, gnt_valid<=1, hold_cnt<=0, go to GRANT.
  - If req==0, remain in IDLE; sel holds its last value.
- Latency: req sampled high at edge k -> gnt_valid=1 after edge k (one clock).
- State GRANT (gnt_valid=1): release at the edge where any of the following is true.
  - (a) done=1.
  - (b) req[sel]=0 (client withdrew).
  - (c) MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1.
  - Otherwise hold_cnt increments. hold_cnt is wide enough for MAX_HOLD and must not wrap.
- On release:
  - gnt_valid<=0, ptr<=sel+1 (mod 4, so 3 wraps to 0), go to IDLE.
  - timeout<=1 only if (c) is the cause and neither (a) nor (b) is also true; otherwise timeout<=0.
  - timeout is high for exactly one cycle.
- Break-before-make:
  - After every release, gnt_valid stays 0 for at least one full cycle.
  - The next grant is issued at the earliest on the following edge.
  - Back-to-back grants are therefore separated by exactly one idle cycle when requests remain pending.
- sel changes only on the edge that raises gnt_valid. It never changes while gnt_valid=1 or on the release edge.
- Simultaneous events:
  - done with req[sel] low: a single release, no timeout.
  - A new req arriving during GRANT is ignored until IDLE.
  - done while in IDLE is ignored.
- Fairness: with all four requests held continuously, the grant order is 0,1,2,3,0,... from reset. No client waits more than 3 other grants.
- Reset asserted mid-grant: gnt_valid drops immediately (asynchronously); ptr returns to 0.
- MAX_HOLD=1: every grant lasts exactly one cycle and releases with timeout=1, unless done or a req drop occurs in that same cycle.

Test Plan:
- Reset/idle: rst_n=0 with req=4'b1111 -> sel=00, gnt_valid=0, timeout=0. Release rst_n with req=0 for 5 cycles -> gnt_valid stays 0.
- Single client: req=4'b0100 at edge k, done pulsed at edge k+3 -> sel=10 and gnt_valid=1 after edges k..k+2, gnt_valid=0 after k+3, sel remains 10.
- Rotation: req=4'b1111 held, done pulsed once per grant -> sel sequence 00,01,10,11,00, each grant separated by one gnt_valid=0 cycle.
- Pointer wrap: grant client 3 then release; next req=4'b1001 -> sel=00, not 11.
- Timeout: MAX_HOLD=8, req=4'b0010 held, done=0 -> gnt_valid high exactly 8 cycles, timeout=1 for one cycle coinciding with gnt_valid falling. With req still held, client 1 is regranted after one idle cycle.
- Withdraw/reset: during grant to client 2, drop req[2] -> release with timeout=0. Then, during a new grant, pulse rst_n low mid-cycle -> gnt_valid=0 immediately. After reset with req=4'b1111 -> first grant sel=00.
